// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: operand/result valid-ready bus for the pipelined Wallace multiplier
interface wallace_mult_pipe_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic approx;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] result;
  logic out_approx;
  modport master (output in_valid, a, b, approx, out_ready, input in_ready, out_valid, result, out_approx);
  modport slave (input in_valid, a, b, approx, out_ready, output in_ready, out_valid, result, out_approx);
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage unsigned Wallace-tree multiplier with per-beat truncated approximate mode
module wallace_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int APPROX_K = 4
) (
  input logic clk,
  input logic rst_n,
  wallace_mult_pipe_if.slave bus
);
  localparam int P = 2*WIDTH;
  localparam int H = WIDTH+3;
  function automatic int layers(int h);
    int n = 0;
    while (h > 2) begin
      h = 2*(h/3) + h%3;
      n++;
    end
    return n;
  endfunction
  localparam int L = layers(WIDTH);
  localparam logic [P-1:0] COMP = P'((2**APPROX_K) >> 1);
  logic adv, v1, v2, v3, x1, x2, x3, z2;
  logic [WIDTH-1:0] a1, b1;
  logic [P-1:0] s0, s1, r0, r1, res;
  logic [H-1:0] cur [P];
  logic [H-1:0] nxt [P];
  int h;
  assign adv = !v3 || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3;
  assign bus.result = res;
  assign bus.out_approx = x3;
  // every column keeps a uniform height so carries from column c-1 land in the odd slots of column c
  always_comb begin
    for (int c = 0; c < P; c++) cur[c] = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        cur[i+j][i] = a1[j] & b1[i] & ~(x1 & (i+j < APPROX_K));
    h = WIDTH;
    for (int l = 0; l < L; l++) begin
      for (int c = 0; c < P; c++) nxt[c] = '0;
      for (int c = 0; c < P; c++) begin
        for (int g = 0; g <= WIDTH/3; g++)
          if (g < h/3) begin
            nxt[c][2*g] = cur[c][3*g] ^ cur[c][3*g+1] ^ cur[c][3*g+2];
            if (c+1 < P) nxt[c+1][2*g+1] = (cur[c][3*g] & cur[c][3*g+1]) | (cur[c][3*g+2] & (cur[c][3*g] ^ cur[c][3*g+1]));
          end
        if (h%3 == 1) nxt[c][2*(h/3)] = cur[c][3*(h/3)];
        if (h%3 == 2) begin
          nxt[c][2*(h/3)] = cur[c][3*(h/3)] ^ cur[c][3*(h/3)+1];
          if (c+1 < P) nxt[c+1][2*(h/3)+1] = cur[c][3*(h/3)] & cur[c][3*(h/3)+1];
        end
      end
      cur = nxt;
      h = 2*(h/3) + h%3;
    end
    for (int c = 0; c < P; c++) begin
      s0[c] = cur[c][0];
      s1[c] = cur[c][1];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      x1 <= 1'b0;
      r0 <= '0;
      r1 <= '0;
      x2 <= 1'b0;
      z2 <= 1'b0;
      res <= '0;
      x3 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      a1 <= bus.a;
      b1 <= bus.b;
      x1 <= bus.approx;
      v2 <= v1;
      r0 <= s0;
      r1 <= s1;
      x2 <= x1;
      z2 <= a1 == '0 || b1 == '0;
      v3 <= v2;
      res <= z2 ? '0 : r0 + r1 + (x2 ? COMP : '0);
      x3 <= x2;
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed and random scoreboard bench for wallace_mult_pipe
module tb_wallace_mult_pipe;
  typedef struct {
    logic [15:0] exp;
    logic ap;
    int cyc;
    logic lat;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic lat_on = 1'b1;
  logic held = 1'b0;
  logic [15:0] prev_res;
  logic prev_ap;
  item_t q[$];
  wallace_mult_pipe_if #(.WIDTH(8)) bus ();
  wallace_mult_pipe_if #(.WIDTH(8)) bk0 ();
  wallace_mult_pipe_if #(.WIDTH(8)) bk8 ();
  wallace_mult_pipe #(.WIDTH(8), .APPROX_K(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  wallace_mult_pipe #(.WIDTH(8), .APPROX_K(0)) dut_k0 (.clk(clk), .rst_n(rst_n), .bus(bk0));
  wallace_mult_pipe #(.WIDTH(8), .APPROX_K(8)) dut_k8 (.clk(clk), .rst_n(rst_n), .bus(bk8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic ap, input int k);
    logic [15:0] s;
    if (!ap) return 16'(x) * 16'(y);
    if (x == 0 || y == 0) return 16'd0;
    s = 16'd0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i + j >= k && x[j] && y[i]) s = s + (16'd1 << (i + j));
    return s + 16'((2**k) >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic ap, input logic [15:0] exp);
    int n = 0;
    bus.a = x;
    bus.b = y;
    bus.approx = ap;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(bus.in_ready), 1);
    if (bus.in_ready) q.push_back('{exp: exp, ap: ap, cyc: cyc, lat: lat_on});
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 0);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (held) begin
        chk("stall_result", 32'(bus.result), 32'(prev_res));
        chk("stall_approx", 32'(bus.out_approx), 32'(prev_ap));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 32'(bus.out_valid), 0);
        else begin
          item_t e;
          e = q.pop_front();
          chk("result", 32'(bus.result), 32'(e.exp));
          chk("out_approx", 32'(bus.out_approx), 32'(e.ap));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 3);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      prev_res = bus.result;
      prev_ap = bus.out_approx;
    end else held = 1'b0;
  initial begin
    logic [7:0] x, y;
    int n;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.approx = 1'b0;
    bus.out_ready = 1'b1;
    bk0.in_valid = 1'b0;
    bk0.a = '0;
    bk0.b = '0;
    bk0.approx = 1'b0;
    bk0.out_ready = 1'b1;
    bk8.in_valid = 1'b0;
    bk8.a = '0;
    bk8.b = '0;
    bk8.approx = 1'b0;
    bk8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_out_approx", 32'(bus.out_approx), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    send(8'd200, 8'd100, 1'b0, 16'd20000);
    send(8'd255, 8'd255, 1'b0, 16'd65025);
    send(8'd0, 8'd37, 1'b0, 16'd0);
    send(8'd255, 8'd255, 1'b1, 16'd64984);
    send(8'd1, 8'd1, 1'b1, 16'd8);
    send(8'd0, 8'd255, 1'b1, 16'd0);
    for (int i = 0; i < 64; i++) begin
      x = 8'($urandom_range(255));
      y = 8'($urandom_range(255));
      send(x, y, 1'(i % 2), model(x, y, 1'(i % 2), 4));
    end
    drain();
    lat_on = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    fork
      begin
        send(8'd11, 8'd13, 1'b0, 16'd143);
        send(8'd255, 8'd3, 1'b1, model(8'd255, 8'd3, 1'b1, 4));
        send(8'd17, 8'd19, 1'b0, 16'd323);
        send(8'd240, 8'd15, 1'b1, model(8'd240, 8'd15, 1'b1, 4));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 0);
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    lat_on = 1'b1;
    send(8'd99, 8'd77, 1'b0, 16'd7623);
    send(8'd55, 8'd66, 1'b1, model(8'd55, 8'd66, 1'b1, 4));
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_result", 32'(bus.result), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bk0.a = 8'd255;
    bk0.b = 8'd255;
    bk0.approx = 1'b1;
    bk0.in_valid = 1'b1;
    bk8.a = 8'd255;
    bk8.b = 8'd255;
    bk8.approx = 1'b1;
    bk8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bk0.in_valid = 1'b0;
    bk8.in_valid = 1'b0;
    n = 0;
    while (!bk0.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("k0_valid", 32'(bk0.out_valid), 1);
    chk("k8_valid", 32'(bk8.out_valid), 1);
    chk("k0_255", 32'(bk0.result), 65025);
    chk("k0_approx", 32'(bk0.out_approx), 1);
    chk("k8_255", 32'(bk8.result), 32'(model(8'd255, 8'd255, 1'b1, 8)));
    @(negedge clk);
    chk("k0_single", 32'(bk0.out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
